// File: rtl/per2axi_req_arbiter_if.sv
// Bundle of the core-side request bus and the per2axi request-channel
// signals. The arbiter uses the slave modport, the environment the master.
interface per2axi_req_arbiter_if #(
    parameter int NB_CORES        = 4,
    parameter int PER_ADDR_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 8
);
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    // core side
    logic [NB_CORES-1:0]                     core_req_i;
    logic [NB_CORES-1:0][PER_ADDR_WIDTH-1:0] core_add_i;
    logic [NB_CORES-1:0]                     core_we_i;
    logic [NB_CORES-1:0][5:0]                core_atop_i;
    logic [NB_CORES-1:0][31:0]               core_wdata_i;
    logic [NB_CORES-1:0][3:0]                core_be_i;
    logic [NB_CORES-1:0]                     core_gnt_o;

    // request-channel side
    logic                      per_req_o;
    logic [PER_ADDR_WIDTH-1:0] per_add_o;
    logic                      per_we_o;
    logic [5:0]                per_atop_o;
    logic [31:0]               per_wdata_o;
    logic [3:0]                per_be_o;
    logic [NB_CORES-1:0]       per_id_o;
    logic                      per_gnt_i;

    // completion and status
    logic                 rsp_valid_i;
    logic [CNT_WIDTH-1:0] outstanding_o;
    logic                 busy_o;
    logic                 err_underflow_o;

    modport slave (
        input  core_req_i, core_add_i, core_we_i, core_atop_i, core_wdata_i, core_be_i,
        output core_gnt_o,
        output per_req_o, per_add_o, per_we_o, per_atop_o, per_wdata_o, per_be_o, per_id_o,
        input  per_gnt_i,
        input  rsp_valid_i,
        output outstanding_o, busy_o, err_underflow_o
    );

    modport master (
        output core_req_i, core_add_i, core_we_i, core_atop_i, core_wdata_i, core_be_i,
        input  core_gnt_o,
        input  per_req_o, per_add_o, per_we_o, per_atop_o, per_wdata_o, per_be_o, per_id_o,
        output per_gnt_i,
        output rsp_valid_i,
        input  outstanding_o, busy_o, err_underflow_o
    );
endinterface

// File: rtl/per2axi_req_arbiter.sv
// Round-robin arbiter from NB_CORES peripheral requesters onto the single
// per2axi request port. The winner's payload is registered, the number of
// in-flight transactions is bounded, and atomics (atop[5]) run alone.
module per2axi_req_arbiter #(
    parameter int NB_CORES        = 4,
    parameter int PER_ADDR_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    per2axi_req_arbiter_if.slave     bus
);
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int IDX_W     = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [NB_CORES-1:0]  ONE_HOT0 = NB_CORES'(1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DRAIN       = 2'd1,
        ISSUE       = 2'd2,
        ATOMIC_WAIT = 2'd3
    } state_e;

    // Registered request presented on the per2axi port, plus the binary
    // index of its owner so the round-robin pointer can advance past it.
    typedef struct packed {
        logic [PER_ADDR_WIDTH-1:0] add;
        logic                      we;
        logic [5:0]                atop;
        logic [31:0]               wdata;
        logic [3:0]                be;
        logic [NB_CORES-1:0]       id;
        logic [IDX_W-1:0]          idx;
    } payload_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Increment modulo NB_CORES.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (v == IDX_W'(NB_CORES - 1)) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    // First set bit of mask scanning from start upwards with wrap-around.
    function automatic pick_t rr_pick(input logic [NB_CORES-1:0] mask,
                                      input logic [IDX_W-1:0]    start);
        pick_t            r;
        logic [IDX_W-1:0] k;
        r = '0;
        k = start;
        for (int i = 0; i < NB_CORES; i++) begin
            if (!r.found && mask[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
            k = wrap_inc(k);
        end
        return r;
    endfunction

    // Saturating in-flight counter update; simultaneous issue and
    // completion cancel out.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] c,
                                                      input logic                 inc,
                                                      input logic                 dec);
        logic [CNT_WIDTH-1:0] r;
        r = c;
        if (inc && !dec && (c != CNT_MAX)) begin
            r = c + 1'b1;
        end else if (dec && !inc && (c != '0)) begin
            r = c - 1'b1;
        end
        return r;
    endfunction

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    payload_t             pl_q, pl_d;

    payload_t             core_pl [NB_CORES];
    pick_t                pick_idle;
    pick_t                pick_b2b;
    logic [NB_CORES-1:0]  b2b_mask;
    logic                 per_req;
    logic                 grant;

    assign per_req = (state_q == ISSUE);
    assign grant   = per_req & bus.per_gnt_i;

    // Gather each core's request into the registered-payload layout.
    always_comb begin
        for (int k = 0; k < NB_CORES; k++) begin
            core_pl[k].add   = bus.core_add_i[k];
            core_pl[k].we    = bus.core_we_i[k];
            core_pl[k].atop  = bus.core_atop_i[k];
            core_pl[k].wdata = bus.core_wdata_i[k];
            core_pl[k].be    = bus.core_be_i[k];
            core_pl[k].id    = ONE_HOT0 << k;
            core_pl[k].idx   = IDX_W'(k);
        end
    end

    // The just-granted core still shows its request in the grant cycle,
    // so it is masked out of the back-to-back pick.
    assign b2b_mask  = bus.core_req_i & ~pl_q.id;
    assign pick_idle = rr_pick(bus.core_req_i, rr_ptr_q);
    assign pick_b2b  = rr_pick(b2b_mask, wrap_inc(pl_q.idx));

    // In-flight counter and sticky underflow flag.
    always_comb begin
        cnt_d = cnt_next(cnt_q, grant, bus.rsp_valid_i);
        err_d = err_q | (bus.rsp_valid_i & ~grant & (cnt_q == '0));
    end

    // Next-state, pointer and payload selection.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        pl_d     = pl_q;
        unique case (state_q)
            IDLE: begin
                if (pick_idle.found && (cnt_q < CNT_MAX)) begin
                    pl_d = core_pl[pick_idle.idx];
                    if (core_pl[pick_idle.idx].atop[5] && (cnt_q != '0)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.per_gnt_i) begin
                    rr_ptr_d = wrap_inc(pl_q.idx);
                    if (pl_q.atop[5]) begin
                        state_d = ATOMIC_WAIT;
                    end else if (pick_b2b.found && (cnt_d < CNT_MAX)) begin
                        pl_d = core_pl[pick_b2b.idx];
                        if (core_pl[pick_b2b.idx].atop[5] && (cnt_d != '0)) begin
                            state_d = DRAIN;
                        end else begin
                            state_d = ISSUE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ATOMIC_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Payload register; cleared on reset so every output starts at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pl_q <= '0;
        end else begin
            pl_q <= pl_d;
        end
    end

    assign bus.core_gnt_o      = grant ? pl_q.id : '0;
    assign bus.per_req_o       = per_req;
    assign bus.per_add_o       = pl_q.add;
    assign bus.per_we_o        = pl_q.we;
    assign bus.per_atop_o      = pl_q.atop;
    assign bus.per_wdata_o     = pl_q.wdata;
    assign bus.per_be_o        = pl_q.be;
    assign bus.per_id_o        = pl_q.id;
    assign bus.outstanding_o   = cnt_q;
    assign bus.busy_o          = per_req | (cnt_q != '0);
    assign bus.err_underflow_o = err_q;
endmodule

// File: tb/tb_per2axi_req_arbiter.sv
// Bench for per2axi_req_arbiter: directed scenarios followed by a random
// run checked against a transaction-level model of the arbitration rules.
module tb_per2axi_req_arbiter;
    localparam int NB  = 4;
    localparam int AW  = 32;
    localparam int MAX = 8;
    localparam int CW  = $clog2(MAX + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    per2axi_req_arbiter_if #(.NB_CORES(NB), .PER_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAX)) bus ();

    per2axi_req_arbiter #(.NB_CORES(NB), .PER_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAX)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [NB-1:0] last_gnt;
    bit            auto_drop;

    function automatic int oh2idx(input logic [NB-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NB; i++) begin
            if (v == (NB'(1) << i)) r = i;
        end
        return r;
    endfunction

    task automatic clear_inputs();
        bus.core_req_i   = '0;
        bus.core_add_i   = '0;
        bus.core_we_i    = '0;
        bus.core_atop_i  = '0;
        bus.core_wdata_i = '0;
        bus.core_be_i    = '0;
        bus.per_gnt_i    = 1'b0;
        bus.rsp_valid_i  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic sample();
        @(negedge clk);
        last_gnt = bus.core_gnt_o;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (auto_drop) bus.core_req_i = bus.core_req_i & ~last_gnt;
    endtask

    task automatic set_core(input int k, input logic [AW-1:0] a, input logic we,
                            input logic [5:0] atop, input logic [31:0] wd, input logic [3:0] be);
        bus.core_add_i[k]   = a;
        bus.core_we_i[k]    = we;
        bus.core_atop_i[k]  = atop;
        bus.core_wdata_i[k] = wd;
        bus.core_be_i[k]    = be;
        bus.core_req_i[k]   = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.per_req_o !== 1'b0) $display("FAIL rst_per_req: got %0h expected 0", bus.per_req_o); else n_pass++;
        n_checks++; if (bus.outstanding_o !== '0) $display("FAIL rst_outstanding: got %0h expected 0", bus.outstanding_o); else n_pass++;
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy: got %0h expected 0", bus.busy_o); else n_pass++;
        n_checks++; if (bus.err_underflow_o !== 1'b0) $display("FAIL rst_err: got %0h expected 0", bus.err_underflow_o); else n_pass++;
        n_checks++; if (bus.per_id_o !== '0) $display("FAIL rst_per_id: got %0h expected 0", bus.per_id_o); else n_pass++;
        n_checks++; if (bus.per_add_o !== '0) $display("FAIL rst_per_add: got %0h expected 0", bus.per_add_o); else n_pass++;
        n_checks++; if (bus.core_gnt_o !== '0) $display("FAIL rst_core_gnt: got %0h expected 0", bus.core_gnt_o); else n_pass++;
    endtask

    task automatic test_single_read();
        do_reset();
        auto_drop     = 1'b1;
        bus.per_gnt_i = 1'b1;
        set_core(2, 32'h1000_0008, 1'b1, 6'd0, 32'hDEAD_BEEF, 4'hF);
        sample();
        n_checks++; if (bus.per_req_o !== 1'b0) $display("FAIL sr_latency0: got %0h expected 0", bus.per_req_o); else n_pass++;
        advance();
        sample();
        n_checks++; if (bus.per_req_o !== 1'b1) $display("FAIL sr_per_req: got %0h expected 1", bus.per_req_o); else n_pass++;
        n_checks++; if (bus.per_id_o !== 4'b0100) $display("FAIL sr_per_id: got %0h expected 4", bus.per_id_o); else n_pass++;
        n_checks++; if (bus.core_gnt_o !== 4'b0100) $display("FAIL sr_core_gnt: got %0h expected 4", bus.core_gnt_o); else n_pass++;
        n_checks++; if (bus.per_add_o !== 32'h1000_0008) $display("FAIL sr_per_add: got %0h expected 10000008", bus.per_add_o); else n_pass++;
        n_checks++; if (bus.per_we_o !== 1'b1) $display("FAIL sr_per_we: got %0h expected 1", bus.per_we_o); else n_pass++;
        advance();
        sample();
        n_checks++; if (bus.outstanding_o !== CW'(1)) $display("FAIL sr_outstanding1: got %0h expected 1", bus.outstanding_o); else n_pass++;
        n_checks++; if (bus.per_req_o !== 1'b0) $display("FAIL sr_req_drop: got %0h expected 0", bus.per_req_o); else n_pass++;
        n_checks++; if (bus.busy_o !== 1'b1) $display("FAIL sr_busy: got %0h expected 1", bus.busy_o); else n_pass++;
        advance();
        bus.rsp_valid_i = 1'b1;
        sample();
        advance();
        bus.rsp_valid_i = 1'b0;
        sample();
        n_checks++; if (bus.outstanding_o !== '0) $display("FAIL sr_outstanding0: got %0h expected 0", bus.outstanding_o); else n_pass++;
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL sr_idle_busy: got %0h expected 0", bus.busy_o); else n_pass++;
    endtask

    task automatic test_round_robin();
        int order[$];
        int gcyc[$];
        int k;
        do_reset();
        auto_drop     = 1'b0;
        bus.per_gnt_i = 1'b1;
        for (int i = 0; i < NB; i++) set_core(i, 32'h100 * i, 1'b1, 6'd0, 32'(i), 4'hF);
        for (int c = 0; c < 12 && order.size() < 5; c++) begin
            sample();
            if (last_gnt != '0) begin
                k = oh2idx(last_gnt);
                order.push_back(k);
                gcyc.push_back(c);
                n_checks++; if (bus.per_add_o !== 32'(32'h100 * k)) $display("FAIL rr_payload: got %0h expected %0h", bus.per_add_o, 32'h100 * k); else n_pass++;
            end
            advance();
        end
        n_checks++; if (order.size() != 5) $display("FAIL rr_count: got %0d grants expected 5", order.size()); else n_pass++;
        for (int i = 0; i < order.size(); i++) begin
            n_checks++; if (order[i] != (i % NB)) $display("FAIL rr_order[%0d]: got core %0d expected core %0d", i, order[i], i % NB); else n_pass++;
        end
        if (gcyc.size() == 5) begin
            n_checks++; if (gcyc[4] - gcyc[0] != 4) $display("FAIL rr_b2b: got span %0d cycles expected 4", gcyc[4] - gcyc[0]); else n_pass++;
        end
        bus.core_req_i = '0;
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a0;
        logic [31:0]   w0;
        logic [NB-1:0] id0;
        int            pulses;
        do_reset();
        auto_drop     = 1'b1;
        bus.per_gnt_i = 1'b0;
        set_core(1, 32'hABCD_0010, 1'b0, 6'd0, 32'h55AA_33CC, 4'h3);
        sample();
        advance();
        sample();
        a0 = bus.per_add_o; w0 = bus.per_wdata_o; id0 = bus.per_id_o;
        n_checks++; if (id0 !== 4'b0010) $display("FAIL bp_id: got %0h expected 2", id0); else n_pass++;
        n_checks++; if (a0 !== 32'hABCD_0010) $display("FAIL bp_add: got %0h expected abcd0010", a0); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            advance();
            sample();
            n_checks++; if ({bus.per_req_o, bus.per_add_o, bus.per_wdata_o, bus.per_id_o} !== {1'b1, a0, w0, id0})
                $display("FAIL bp_hold[%0d]: got req %0h add %0h wdata %0h id %0h", c, bus.per_req_o, bus.per_add_o, bus.per_wdata_o, bus.per_id_o); else n_pass++;
            n_checks++; if (bus.core_gnt_o !== '0) $display("FAIL bp_no_gnt[%0d]: got %0h expected 0", c, bus.core_gnt_o); else n_pass++;
        end
        advance();
        bus.per_gnt_i = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            sample();
            if (last_gnt != '0) pulses++;
            advance();
        end
        n_checks++; if (pulses != 1) $display("FAIL bp_pulses: got %0d expected 1", pulses); else n_pass++;
    endtask

    task automatic test_outstanding_limit();
        int  issued;
        int  grants;
        bit  got9;
        do_reset();
        auto_drop     = 1'b0;
        bus.per_gnt_i = 1'b1;
        issued = 1;
        grants = 0;
        set_core(0, 32'h3000_0000, 1'b1, 6'd0, 32'd0, 4'hF);
        for (int c = 0; c < 30; c++) begin
            sample();
            if (last_gnt[0]) grants++;
            advance();
            if (last_gnt[0]) begin
                if (issued < 10) begin
                    issued++;
                    bus.core_add_i[0] = bus.core_add_i[0] + 32'd4;
                end else begin
                    bus.core_req_i[0] = 1'b0;
                end
            end
        end
        sample();
        n_checks++; if (grants != 8) $display("FAIL lim_grants: got %0d expected 8", grants); else n_pass++;
        n_checks++; if (bus.outstanding_o !== CW'(8)) $display("FAIL lim_outstanding: got %0d expected 8", bus.outstanding_o); else n_pass++;
        n_checks++; if (bus.per_req_o !== 1'b0) $display("FAIL lim_per_req: got %0h expected 0", bus.per_req_o); else n_pass++;
        advance();
        bus.rsp_valid_i = 1'b1;
        sample();
        advance();
        bus.rsp_valid_i = 1'b0;
        got9 = 1'b0;
        for (int c = 0; c < 6 && !got9; c++) begin
            sample();
            if (last_gnt[0]) got9 = 1'b1;
            advance();
        end
        n_checks++; if (!got9) $display("FAIL lim_ninth: got no grant expected one after a response"); else n_pass++;
        sample();
        n_checks++; if (bus.outstanding_o !== CW'(8)) $display("FAIL lim_refill: got %0d expected 8", bus.outstanding_o); else n_pass++;
    endtask

    task automatic test_atomic_ordering();
        int            grants;
        logic [NB-1:0] first_gnt;
        logic [5:0]    first_atop;
        logic [CW-1:0] cnt_at_gnt;
        do_reset();
        auto_drop     = 1'b1;
        bus.per_gnt_i = 1'b1;
        set_core(0, 32'h4000_0000, 1'b1, 6'd0, 32'd0, 4'hF);
        set_core(2, 32'h4000_0008, 1'b1, 6'd0, 32'd0, 4'hF);
        set_core(3, 32'h4000_000C, 1'b1, 6'd0, 32'd0, 4'hF);
        grants = 0;
        for (int c = 0; c < 10 && grants < 3; c++) begin
            sample();
            if (last_gnt != '0) grants++;
            advance();
        end
        set_core(1, 32'h2000_0000, 1'b0, 6'b100010, 32'h1234_5678, 4'hF);
        sample();
        n_checks++; if (bus.outstanding_o !== CW'(3)) $display("FAIL at_three_out: got %0d expected 3", bus.outstanding_o); else n_pass++;
        advance();
        set_core(0, 32'h4000_0100, 1'b1, 6'd0, 32'd0, 4'hF);
        for (int c = 0; c < 4; c++) begin
            sample();
            n_checks++; if ({bus.per_req_o, bus.core_gnt_o} !== {1'b0, 4'b0000}) $display("FAIL at_drain[%0d]: got req %0h gnt %0h expected 0 0", c, bus.per_req_o, bus.core_gnt_o); else n_pass++;
            advance();
        end
        bus.rsp_valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            n_checks++; if (bus.core_gnt_o !== '0) $display("FAIL at_drain_rsp[%0d]: got %0h expected 0", c, bus.core_gnt_o); else n_pass++;
            advance();
        end
        bus.rsp_valid_i = 1'b0;
        first_gnt = '0; first_atop = '0; cnt_at_gnt = '1;
        for (int c = 0; c < 6 && first_gnt == '0; c++) begin
            sample();
            if (last_gnt != '0) begin
                first_gnt = last_gnt; first_atop = bus.per_atop_o; cnt_at_gnt = bus.outstanding_o;
            end
            advance();
        end
        n_checks++; if (first_gnt !== 4'b0010) $display("FAIL at_first: got %0h expected 2", first_gnt); else n_pass++;
        n_checks++; if (first_atop !== 6'b100010) $display("FAIL at_atop: got %0h expected 22", first_atop); else n_pass++;
        n_checks++; if (cnt_at_gnt !== '0) $display("FAIL at_count_zero: got %0d expected 0", cnt_at_gnt); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            sample();
            n_checks++; if ({bus.core_gnt_o, bus.outstanding_o} !== {4'b0000, CW'(1)}) $display("FAIL at_wait[%0d]: got gnt %0h out %0d expected 0 1", c, bus.core_gnt_o, bus.outstanding_o); else n_pass++;
            advance();
        end
        bus.rsp_valid_i = 1'b1;
        sample();
        advance();
        bus.rsp_valid_i = 1'b0;
        first_gnt = '0;
        for (int c = 0; c < 6 && first_gnt == '0; c++) begin
            sample();
            if (last_gnt != '0) begin
                first_gnt = last_gnt; cnt_at_gnt = bus.outstanding_o;
            end
            advance();
        end
        n_checks++; if (first_gnt !== 4'b0001) $display("FAIL at_after: got %0h expected 1", first_gnt); else n_pass++;
        n_checks++; if (cnt_at_gnt !== '0) $display("FAIL at_after_cnt: got %0d expected 0", cnt_at_gnt); else n_pass++;
    endtask

    task automatic test_underflow_reset();
        bit got;
        do_reset();
        auto_drop       = 1'b1;
        bus.rsp_valid_i = 1'b1;
        sample();
        advance();
        bus.rsp_valid_i = 1'b0;
        sample();
        n_checks++; if (bus.err_underflow_o !== 1'b1) $display("FAIL uf_flag: got %0h expected 1", bus.err_underflow_o); else n_pass++;
        n_checks++; if (bus.outstanding_o !== '0) $display("FAIL uf_count: got %0d expected 0", bus.outstanding_o); else n_pass++;
        advance();
        bus.per_gnt_i = 1'b1;
        set_core(0, 32'h5000_0000, 1'b1, 6'd0, 32'd0, 4'hF);
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            sample();
            if (last_gnt != '0) got = 1'b1;
            advance();
        end
        bus.per_gnt_i = 1'b0;
        set_core(1, 32'h5000_0004, 1'b0, 6'd0, 32'hCAFE_F00D, 4'hF);
        sample();
        advance();
        sample();
        n_checks++; if ({bus.per_req_o, bus.outstanding_o, bus.err_underflow_o} !== {1'b1, CW'(1), 1'b1})
            $display("FAIL uf_pre_reset: got req %0h out %0d err %0h expected 1 1 1", bus.per_req_o, bus.outstanding_o, bus.err_underflow_o); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.per_req_o !== 1'b0) $display("FAIL rst_mid_req: got %0h expected 0", bus.per_req_o); else n_pass++;
        n_checks++; if (bus.outstanding_o !== '0) $display("FAIL rst_mid_out: got %0d expected 0", bus.outstanding_o); else n_pass++;
        n_checks++; if (bus.err_underflow_o !== 1'b0) $display("FAIL rst_mid_err: got %0h expected 0", bus.err_underflow_o); else n_pass++;
        n_checks++; if (bus.core_gnt_o !== '0) $display("FAIL rst_mid_gnt: got %0h expected 0", bus.core_gnt_o); else n_pass++;
        clear_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Random traffic. The model only knows the arbitration rules: each core
    // holds one request until granted, a grant moves the presented payload,
    // the count is grants minus completions, atomics start at count 0 and
    // nothing else is granted until the count returns to 0.
    task automatic test_random();
        bit            pend [NB];
        int            age  [NB];
        logic [AW-1:0] e_add  [NB];
        logic          e_we   [NB];
        logic [5:0]    e_atop [NB];
        logic [31:0]   e_wd   [NB];
        logic [3:0]    e_be   [NB];
        int            mcnt;
        int            max_age;
        int            k;
        bit            atomic_busy;
        bit            hold;
        bit            leftover;
        logic [AW+1+6+32+4+NB-1:0] prev_pl;
        logic [AW+1+6+32+4+NB-1:0] cur_pl;
        do_reset();
        auto_drop   = 1'b0;
        mcnt        = 0;
        max_age     = 0;
        atomic_busy = 1'b0;
        hold        = 1'b0;
        prev_pl     = '0;
        for (int i = 0; i < NB; i++) begin pend[i] = 1'b0; age[i] = 0; end
        bus.per_gnt_i = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sample();
            cur_pl = {bus.per_add_o, bus.per_we_o, bus.per_atop_o, bus.per_wdata_o, bus.per_be_o, bus.per_id_o};
            n_checks++; if (last_gnt !== ((bus.per_req_o && bus.per_gnt_i) ? bus.per_id_o : '0))
                $display("FAIL rnd_gnt@%0d: got %0h with req %0h gnt %0h id %0h", cyc, last_gnt, bus.per_req_o, bus.per_gnt_i, bus.per_id_o); else n_pass++;
            n_checks++; if (bus.outstanding_o !== CW'(mcnt)) $display("FAIL rnd_count@%0d: got %0d expected %0d", cyc, bus.outstanding_o, mcnt); else n_pass++;
            n_checks++; if (bus.busy_o !== (bus.per_req_o | (mcnt != 0))) $display("FAIL rnd_busy@%0d: got %0h expected %0h", cyc, bus.busy_o, bus.per_req_o | (mcnt != 0)); else n_pass++;
            n_checks++; if (bus.err_underflow_o !== 1'b0) $display("FAIL rnd_err@%0d: got %0h expected 0", cyc, bus.err_underflow_o); else n_pass++;
            if (bus.per_req_o) begin
                k = oh2idx(bus.per_id_o);
                n_checks++;
                if (k < 0) $display("FAIL rnd_id@%0d: got %0h expected a one-hot id", cyc, bus.per_id_o);
                else if (!pend[k] || cur_pl !== {e_add[k], e_we[k], e_atop[k], e_wd[k], e_be[k], NB'(1) << k})
                    $display("FAIL rnd_payload@%0d: got add %0h atop %0h for core %0d expected add %0h atop %0h pending %0d", cyc, bus.per_add_o, bus.per_atop_o, k, e_add[k], e_atop[k], pend[k]);
                else n_pass++;
            end
            if (hold) begin
                n_checks++; if ({bus.per_req_o, cur_pl} !== {1'b1, prev_pl}) $display("FAIL rnd_stable@%0d: got req %0h payload %0h expected 1 %0h", cyc, bus.per_req_o, cur_pl, prev_pl); else n_pass++;
            end
            if (last_gnt != '0) begin
                n_checks++; if (atomic_busy) $display("FAIL rnd_atomic_excl@%0d: got grant %0h expected none while atomic in flight", cyc, last_gnt); else n_pass++;
                if (bus.per_atop_o[5]) begin
                    n_checks++; if (mcnt != 0) $display("FAIL rnd_atomic_drain@%0d: got count %0d at atomic grant expected 0", cyc, mcnt); else n_pass++;
                end
            end
            hold    = bus.per_req_o && !bus.per_gnt_i;
            prev_pl = cur_pl;
            if (last_gnt != '0) mcnt++;
            if (bus.rsp_valid_i) mcnt--;
            if (last_gnt != '0 && bus.per_atop_o[5]) atomic_busy = 1'b1;
            else if (mcnt == 0) atomic_busy = 1'b0;
            n_checks++; if (mcnt > MAX) $display("FAIL rnd_limit@%0d: got %0d in flight expected at most %0d", cyc, mcnt, MAX); else n_pass++;
            for (int i = 0; i < NB; i++) begin
                if (pend[i]) begin
                    age[i]++;
                    if (age[i] > max_age) max_age = age[i];
                end
            end
            advance();
            for (int i = 0; i < NB; i++) begin
                if (last_gnt[i]) begin pend[i] = 1'b0; age[i] = 0; end
                if (!pend[i] && cyc < 2600 && $urandom_range(0, 3) == 0) begin
                    pend[i]   = 1'b1;
                    e_add[i]  = $urandom();
                    e_we[i]   = 1'($urandom_range(0, 1));
                    e_atop[i] = ($urandom_range(0, 9) == 0) ? {1'b1, 5'($urandom())} : 6'd0;
                    e_wd[i]   = $urandom();
                    e_be[i]   = 4'($urandom());
                end
                bus.core_req_i[i]   = pend[i];
                bus.core_add_i[i]   = e_add[i];
                bus.core_we_i[i]    = e_we[i];
                bus.core_atop_i[i]  = e_atop[i];
                bus.core_wdata_i[i] = e_wd[i];
                bus.core_be_i[i]    = e_be[i];
            end
            bus.per_gnt_i   = ($urandom_range(0, 3) != 0);
            bus.rsp_valid_i = (mcnt > 0) && ($urandom_range(0, 2) == 0);
        end
        leftover = 1'b0;
        for (int i = 0; i < NB; i++) if (pend[i]) leftover = 1'b1;
        n_checks++; if (leftover) $display("FAIL rnd_drain: got requests still pending expected none"); else n_pass++;
        n_checks++; if (max_age > 400) $display("FAIL rnd_starve: got wait of %0d cycles expected at most 400", max_age); else n_pass++;
        clear_inputs();
    endtask

    initial begin
        auto_drop = 1'b0;
        last_gnt  = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_backpressure();
        test_outstanding_limit();
        test_atomic_ordering();
        test_underflow_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/per2axi_req_arbiter.md
Name: per2axi_req_arbiter

Overview:
- Arbitrates NB_CORES core-side peripheral requests onto the single peripheral slave port of the per2axi request channel.
- Uses round-robin selection and registers the winning request's payload.
- Limits the number of in-flight AXI transactions.
- Serialises atomic operations (atop[5]=1) so they never overlap other traffic.
- Sits between the cluster peripheral interconnect and the per2axi request channel; completions come back from the response channel.

Parameters:
- NB_CORES, 4, number of requesting cores.
- PER_ADDR_WIDTH, 32, address width.
- MAX_OUTSTANDING, 8, maximum granted-but-not-completed transactions (at least 1).
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), outstanding counter width. Derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Asynchronous, active-low.
- core_req_i  in  NB_CORES  request per core.
- core_add_i  in  NB_CORES x PER_ADDR_WIDTH  address.
- core_we_i  in  NB_CORES  interconnect convention: 0 = write, 1 = read.
- core_atop_i  in  NB_CORES x 6  atomic opcode; bit 5 marks an atomic.
- core_wdata_i  in  NB_CORES x 32  write data.
- core_be_i  in  NB_CORES x 4  byte enables.
- core_gnt_o  out  NB_CORES  grant per core.
- per_req_o  out  1  request to the request channel.
- per_add_o, per_we_o, per_atop_o, per_wdata_o, per_be_o  out  as per core  registered payload.
- per_id_o  out  NB_CORES  one-hot id of the selected core.
- per_gnt_i  in  1  grant from the request channel.
- rsp_valid_i  in  1  one transaction completed (R or B accepted).
- outstanding_o  out  CNT_WIDTH  current in-flight count.
- busy_o  out  1  asserted when per_req_o=1 or outstanding_o!=0.
- err_underflow_o  out  1  sticky flag: completion received while count was 0.

Behaviour:
- Reset (async assert, sync deassert):
  - State IDLE; rr_ptr=0; count=0.
  - All outputs 0, including per_req_o and the payload registers.
  - Reset mid-transaction drops per_req_o immediately; the in-flight count is discarded.
- Eligibility:
  - A core is eligible if core_req_i[k]=1.
  - The issue path is open if count<MAX_OUTSTANDING.
- Selection: the first eligible k scanning rr_ptr, rr_ptr+1, ... with wrap modulo NB_CORES.
  - On selection, latch core k's payload into per_* registers and set per_id_o = onehot(k).
  - per_req_o rises the next cycle, so core request to per_req_o latency is 1 cycle.
- Stability: while per_req_o=1 and per_gnt_i=0, every per_* output holds constant.
- Grant handshake:
  - core_gnt_o[k] = per_req_o & per_gnt_i & per_id_o[k], combinational and same cycle.
  - All other core_gnt_o bits are 0.
  - On grant, rr_ptr <= (k+1) mod NB_CORES.
- States:
  - IDLE: if a selection exists and the issue path is open:
    - non-atomic -> ISSUE;
    - atomic with count==0 -> ISSUE;
    - atomic with count!=0 -> DRAIN.
    - The payload is latched in the selection cycle in every case.
  - DRAIN: per_req_o=0; wait until count==0, then -> ISSUE.
  - ISSUE: per_req_o=1. On per_gnt_i:
    - atomic -> ATOMIC_WAIT;
    - non-atomic -> back-to-back reselection in the same cycle, with the just-granted core excluded that cycle. If there is a new selection and the issue path remains open after the increment, reload the payload and stay in ISSUE; otherwise -> IDLE.
    - A back-to-back reselection of an atomic when count+1 != 0 -> DRAIN.
  - ATOMIC_WAIT: no new selection; when count returns to 0 -> IDLE.
- Counter:
  - +1 on per_req_o&per_gnt_i.
  - -1 on rsp_valid_i.
  - Both in the same cycle -> unchanged.
  - rsp_valid_i with count==0 -> count stays 0 and err_underflow_o is set until reset.
  - Count never exceeds MAX_OUTSTANDING.
  - When count==MAX_OUTSTANDING, no new selection is made. A request already presented in ISSUE stays presented and cannot be granted beyond the limit because it was selected when count<MAX.

Test Plan:
- Single read: core 2 req, we=1, addr 0x1000_0008, per_gnt_i tied 1 -> per_req_o=1 at cycle +1 with per_id_o=4'b0100, core_gnt_o=4'b0100 that cycle, outstanding_o=1; rsp_valid_i -> 0.
- Round-robin: all 4 cores request continuously with gnt=1 -> grant order 0,1,2,3,0, one per cycle after the first; rr_ptr wraps 3->0.
- Backpressure: per_gnt_i=0 for 5 cycles -> per_add_o, per_wdata_o and per_id_o unchanged across all 5 cycles and core_gnt_o=0; grant on cycle 6 -> exactly one core_gnt_o pulse.
- Outstanding limit: MAX_OUTSTANDING=8, no responses, 10 requests -> exactly 8 grants, outstanding_o=8, per_req_o=0; one rsp_valid_i -> 9th grant occurs.
- Atomic ordering: 3 reads outstanding, core 1 issues atop=6'b100010 -> DRAIN, per_req_o=0 until 3 responses, then atomic issued. A core-0 read arriving meanwhile is not granted until the atomic completes (count back to 0).
- Reset/underflow: rsp_valid_i with count 0 -> err_underflow_o=1 and count stays 0; assert rst_ni=0 mid-ISSUE -> per_req_o=0 in the same cycle, outstanding_o=0, err_underflow_o=0.
